// File: rtl/ctrl_dispatch.sv
// Command dispatcher for the cache controller: arbitrates two requesters,
// sequences one GET/PUT/DEL sub-FSM at a time and returns a response.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[1:0]        per-port command valid (bit i = port i)
//   req_op[3:0]           per-port opcode, port i at [2i+1:2i]
//                         00 GET, 01 PUT, 10 DEL, 11 illegal
//   req_ready[1:0]        per-port accept, at most one bit high
//   op_enter[2:0]         one-cycle start pulse (0 GET, 1 PUT, 2 DEL)
//   op_en[2:0]            run enable, one-hot or zero
//   op_done[2:0]          sub-FSM completion, sampled in RUN
//   op_err[2:0]           sub-FSM error, sampled with op_done
//   rsp_valid, rsp_ready  response handshake
//   rsp_id                port that issued the completed command
//   rsp_err               sub-FSM error or illegal opcode
//   rsp_timeout           operation aborted by timeout
//   busy                  high in every state except IDLE
module ctrl_dispatch #(
    parameter int TIMEOUT   = 200,
    parameter int TIMEOUT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_op,
    output logic [1:0] req_ready,
    output logic [2:0] op_enter,
    output logic [2:0] op_en,
    input  logic [2:0] op_done,
    input  logic [2:0] op_err,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       busy
);

    localparam logic [1:0] OP_ILL = 2'b11;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST =
        TIMEOUT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state, state_d;
    logic                 prio, prio_d;
    logic [1:0]           op_q, op_d;
    logic                 id_q, id_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 to_q, to_d;

    logic                 req_any;
    logic                 gnt_id;
    logic [1:0]           gnt_op;
    logic [2:0]           op_oh;
    logic                 act_done;
    logic                 act_err;

    // Grant and active-op decode. op_oh is zero for the illegal
    // opcode because the shifted-out bit falls off the 3-bit result.
    always_comb begin
        req_any  = |req_valid;
        gnt_id   = (req_valid == 2'b11) ? prio : req_valid[1];
        gnt_op   = gnt_id ? req_op[3:2] : req_op[1:0];
        op_oh    = 3'b001 << op_q;
        act_done = |(op_done & op_oh);
        act_err  = |(op_err & op_oh);
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && req_any) begin
            req_ready = gnt_id ? 2'b10 : 2'b01;
        end
        op_enter    = (state == ENTER) ? op_oh : 3'b000;
        op_en       = (state == RUN) ? op_oh : 3'b000;
        rsp_valid   = (state == RESP);
        busy        = (state != IDLE);
        rsp_id      = id_q;
        rsp_err     = err_q;
        rsp_timeout = to_q;
    end

    always_comb begin
        state_d = state;
        prio_d  = prio;
        op_d    = op_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        to_d    = to_q;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    op_d = gnt_op;
                    id_d = gnt_id;
                    if (gnt_op == OP_ILL) begin
                        err_d   = 1'b1;
                        to_d    = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = ENTER;
                    end
                end
            end
            ENTER: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // done has priority over a timeout in the same cycle
                if (act_done) begin
                    err_d   = act_err;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    // just-served port drops to lowest priority
                    prio_d  = ~id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
            op_q  <= 2'b00;
            id_q  <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            state <= state_d;
            prio  <= prio_d;
            op_q  <= op_d;
            id_q  <= id_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            to_q  <= to_d;
        end
    end

endmodule

// File: tb/tb_ctrl_dispatch.sv
// Self-checking bench for ctrl_dispatch: transaction-level model
// predicts grant, op_enter/op_en windows and response per command.
module tb_ctrl_dispatch;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] req_op;
    logic [1:0] req_ready;
    logic [2:0] op_enter;
    logic [2:0] op_en;
    logic [2:0] op_done;
    logic [2:0] op_err;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    logic m_prio = 1'b0;

    ctrl_dispatch #(.TIMEOUT(T), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op),
        .req_ready(req_ready),
        .op_enter(op_enter), .op_en(op_en),
        .op_done(op_done), .op_err(op_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] op_bit(input logic [1:0] op);
        case (op)
            2'd0: return 3'b001;
            2'd1: return 3'b010;
            2'd2: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // One command from offer to response handshake.
    // v: valid in accept cycle, vb: valid while busy,
    // lat: op_en cycle on which done is raised (0 = never),
    // wt: cycles rsp_ready is held low after rsp_valid.
    task automatic txn(input string nm, input logic [1:0] v,
                       input logic [1:0] vb,
                       input logic [1:0] o0, input logic [1:0] o1,
                       input int lat, input logic e, input int wt);
        logic [9:0] act, exp;
        logic [2:0] ex_f, ac_f, oh, d, er;
        logic [1:0] op;
        logic       gid, legal, ok, fin;
        int         n, rc;
        @(negedge clk);
        req_valid = v;
        req_op    = {o1, o0};
        op_done   = 3'($urandom);
        op_err    = 3'($urandom);
        rsp_ready = 1'($urandom);
        #1;
        gid = (v == 2'b11) ? m_prio : v[1];
        exp = {(gid ? 2'b10 : 2'b01), 8'b0};
        act = {req_ready, op_enter, op_en, rsp_valid, busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s accept got %h exp %h", nm, act, exp);
        end
        @(posedge clk);
        op    = gid ? o1 : o0;
        oh    = op_bit(op);
        legal = (op != 2'b11);
        ok    = (lat >= 1 && lat <= T);
        n     = ok ? lat : T;
        rc    = legal ? n + 2 : 1;
        ex_f  = {gid, legal ? (ok ? e : 1'b0) : 1'b1,
                 legal && !ok};
        fin   = 1'b0;
        for (int c = 1; c < 60 && !fin; c++) begin
            @(negedge clk);
            req_valid = vb;
            rsp_ready = (c >= rc + wt);
            d  = 3'($urandom);
            er = 3'($urandom);
            if (legal && c >= 2 && c < 2 + n) begin
                d = d & ~oh;
                if (ok && c == lat + 1) d = d | oh;
                er = (er & ~oh) | (e ? oh : 3'b000);
            end
            op_done = d;
            op_err  = er;
            #1;
            exp = {2'b00,
                   (legal && c == 1) ? oh : 3'b000,
                   (legal && c >= 2 && c < 2 + n) ? oh : 3'b000,
                   c >= rc, 1'b1};
            act = {req_ready, op_enter, op_en, rsp_valid, busy};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s cyc %0d got %h exp %h",
                         nm, c, act, exp);
            end
            if (c >= rc) begin
                ac_f = {rsp_id, rsp_err, rsp_timeout};
                checks++;
                if (ac_f !== ex_f) begin
                    errors++;
                    $display("FAIL %s rsp cyc %0d got %b exp %b",
                             nm, c, ac_f, ex_f);
                end
            end
            @(posedge clk);
            if (rsp_ready) fin = 1'b1;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s no handshake got 0 exp 1", nm);
        end
        m_prio = ~gid;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_prio = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] act;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_op    = 4'b0;
        op_done   = 3'b0;
        op_err    = 3'b0;
        rsp_ready = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            act = {req_ready, op_enter, op_en, rsp_valid,
                   rsp_id, rsp_err, rsp_timeout, busy};
            checks++;
            if (act !== 13'b0) begin
                errors++;
                $display("FAIL reset%0d got %h exp 0", i, act);
            end
            @(negedge clk);
            rst_n = 1'b1;
            #1;
        end
        m_prio = 1'b0;
    endtask

    task automatic test_get();
        txn("get", 2'b01, 2'b00, 2'd0, 2'd1, 3, 1'b0, 0);
    endtask

    task automatic test_alternate();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            txn("alt", 2'b11, 2'b11, 2'd1, 2'd2, 1,
                1'($urandom), 0);
        end
    endtask

    task automatic test_timeout();
        txn("tmo", 2'b10, 2'b00, 2'd0, 2'd2, 0, 1'b1, 0);
        txn("tmo_edge", 2'b01, 2'b00, 2'd1, 2'd0, T, 1'b1, 0);
    endtask

    task automatic test_illegal();
        txn("ill", 2'b01, 2'b00, 2'd3, 2'd0, 1, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        txn("bp", 2'b01, 2'b10, 2'd0, 2'd1, 1, 1'b1, 5);
        txn("bp_next", 2'b10, 2'b00, 2'd2, 2'd1, 2, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        logic [12:0] act;
        logic [1:0]  ac2;
        txn("pre", 2'b01, 2'b00, 2'd0, 2'd0, 1, 1'b0, 0);
        @(negedge clk);
        req_valid = 2'b01;
        req_op    = 4'b0001;
        op_done   = 3'b000;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (op_en !== 3'b010) begin
            errors++;
            $display("FAIL rmid_run got %b exp 010", op_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        act = {req_ready, op_enter, op_en, rsp_valid,
               rsp_id, rsp_err, rsp_timeout, busy};
        checks++;
        if (act !== 13'b0) begin
            errors++;
            $display("FAIL rmid_out got %h exp 0", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            ac2 = {rsp_valid, busy};
            checks++;
            if (ac2 !== 2'b00) begin
                errors++;
                $display("FAIL rmid_idle got %b exp 00", ac2);
            end
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rmid_prio got %b exp 01", req_ready);
        end
        req_valid = 2'b00;
        m_prio    = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            txn("rnd", 2'($urandom_range(1, 3)), 2'($urandom),
                2'($urandom), 2'($urandom),
                $urandom_range(0, 6), 1'($urandom),
                $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_get();
        test_alternate();
        test_timeout();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_dispatch.md
# ctrl_dispatch

Command dispatcher for the cache controller. It arbitrates between two command requesters: port 0 is the host command decoder, port 1 is the maintenance/expiry engine. It then sequences exactly one operation sub-FSM (GET, PUT, DEL) at a time by pulsing that FSM's `enter` and holding its `en`. Completion or timeout is returned on a valid/ready response channel.

## Interface
Parameters:
- `TIMEOUT`, default 200: maximum RUN cycles before an operation is aborted; legal range 2..2^TIMEOUT_W-1.
- `TIMEOUT_W`, default 8: width of the RUN cycle counter.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  2: per-port command valid; bit i belongs to port i.
- `req_op`  in  2×2: per-port opcode (`req_op[i]`). 00 = GET, 01 = PUT, 10 = DEL, 11 = illegal.
- `req_ready`  out  2: per-port accept. At most one bit is high in any cycle.
- `op_enter`  out  3: one-cycle start pulse to each sub-FSM; index 0 = GET, 1 = PUT, 2 = DEL.
- `op_en`  out  3: run enable to each sub-FSM; one-hot or zero.
- `op_done`  in  3: sub-FSM completion, sampled only in RUN for the active op.
- `op_err`  in  3: sub-FSM error flag, sampled together with `op_done`.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response accept.
- `rsp_id`  out  1: port that issued the completed command.
- `rsp_err`  out  1: operation reported an error, or the opcode was illegal.
- `rsp_timeout`  out  1: operation aborted by timeout.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, ENTER, RUN, RESP.
- **IDLE**
  - Arbitration:
    - One port valid: that port is granted.
    - Both ports valid: the port equal to the priority bit `prio` is granted.
  - `req_ready` is high for the granted port only, in the same cycle (combinational from `req_valid` and `prio`).
  - On handshake, latch `op` and `id`, then:
    - op 11 goes to RESP with `rsp_err=1` and `rsp_timeout=0`; no sub-FSM is touched.
    - Any other op goes to ENTER.
- **ENTER**
  - `op_enter[op]=1` for exactly one cycle; all `op_en` bits are 0.
  - `op_done` is ignored in this state.
  - Clear the counter to 0, then go to RUN.
- **RUN**
  - `op_en[op]=1`; all other `op_en` and `op_enter` bits are 0.
  - If `op_done[op]` is 1: capture `rsp_err=op_err[op]`, set `rsp_timeout=0`, go to RESP.
  - Otherwise, if counter == TIMEOUT-1: set `rsp_timeout=1` and `rsp_err=0`, go to RESP.
  - Otherwise, counter increments by 1.
  - `done` wins over timeout when both occur in the same cycle.
  - `op_done`/`op_err` bits of non-active ops are ignored.
- **RESP**
  - `rsp_valid=1`, with `rsp_id`, `rsp_err` and `rsp_timeout` held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`:
    - `prio` is set to the inverse of `id`, so the just-served port gets lowest priority.
    - Go to IDLE.
  - `req_ready` is 0 in every state except IDLE; no new command is accepted while busy.
- **Reset** (asynchronous assert, synchronous to `clk` on deassert):
  - State goes to IDLE, `prio` to 0, counter to 0.
  - `req_ready` = 0 when no request is valid.
  - `op_enter`, `op_en`, `rsp_valid`, `rsp_id`, `rsp_err`, `rsp_timeout` and `busy` are all 0.
- **Reset mid-operation**: the active sub-FSM loses `op_en` immediately and no response is produced. The sub-FSMs have their own resets.

## Timing
- The accept cycle (IDLE handshake) is cycle 0.
- `op_enter` is high in cycle 1.
- `op_en` is high from cycle 2 onward.
- If `op_done` is sampled high in RUN cycle k (k ≥ 2), `rsp_valid` rises in cycle k+1.
- Minimum accept-to-`rsp_valid` latency is 3 cycles. An illegal op gives 1 cycle (`rsp_valid` in cycle 1).
- Timeout: `op_en` is high for exactly TIMEOUT cycles, and `rsp_valid` rises the cycle after the last one.
- If `rsp_ready` is high when `rsp_valid` rises, the response lasts 1 cycle and the next command can be accepted in the following cycle. Back-to-back throughput is one op per (RUN length + 3) cycles.

## Test plan
- Port 0 issues GET, and the GET FSM raises `op_done` on its 3rd `op_en` cycle with `op_err=0`. Expect:
  - `op_enter=001` in cycle 1.
  - `op_en=001` in cycles 2–4.
  - `rsp_valid` in cycle 5 with `rsp_id=0`, `rsp_err=0`, `rsp_timeout=0`.
- Both ports are valid continuously with PUT and DEL, and each FSM responds done after 1 cycle. Expect grant order port 0, 1, 0, 1, and each port's `req_ready` high only in IDLE.
- TIMEOUT=4, port 1 issues DEL, and `op_done` is never raised. Expect:
  - `op_en=100` for exactly 4 cycles.
  - `rsp_timeout=1`, `rsp_err=0`, `rsp_id=1`.
  - `op_en` returns to 0 in RESP.
- Port 0 issues op 11. Expect:
  - `rsp_valid` in cycle 1 with `rsp_err=1`.
  - `op_enter` and `op_en` stay 000 throughout.
- `rsp_ready` is held low for 5 cycles after `rsp_valid`, with a new port 1 request pending. Expect:
  - Response fields stable, `req_ready=00` throughout.
  - Port 1 accepted the cycle after the response handshake.
- `rst_n` is asserted during RUN of a PUT. Expect all outputs 0 immediately, no `rsp_valid` after release, and `prio=0`.
